// File: rtl/pwm_capture_pkg.sv
// ============================================================================
// pwm_capture_pkg : register map, CTRL bit positions and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package pwm_capture_pkg;

    localparam logic [1:0] ADDR_WIDTH   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_VALID    = 1;
    localparam int CTRL_TIMEOUT  = 2;
    localparam int CTRL_LEVEL    = 3;
    localparam int CTRL_IRQ_EN   = 4;
    localparam int CTRL_IRQ_PEND = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_edge_sync.sv
// ============================================================================
// pwm_edge_sync : multi-flop synchronizer plus rise/fall edge detector
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

`default_nettype wire

// File: rtl/pwm_capture_avalon.sv
// ============================================================================
// pwm_capture_avalon : Avalon-MM PWM receiver measuring high time and period.
// Optional interrupt output enabled by defining PWM_CAPTURE_IRQ_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_capture_avalon
    import pwm_capture_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_DEFAULT = 32'd1000000,
    parameter int          SYNC_STAGES     = 2
) (
    input  logic        csi_clk,
    input  logic        rsi_rst_n,
    input  logic        avs_s0_chip_select,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [1:0]  avs_s0_address,
    input  logic [3:0]  avs_s0_byteenable,
    input  logic [31:0] avs_s0_writedata,
    output logic [31:0] avs_s0_readdata,
`ifdef PWM_CAPTURE_IRQ_EN
    output logic        ins_irq,
`endif
    input  logic        coe_pwm_in
);

    logic        pwm_level, pwm_rise, pwm_fall;
    logic        wr_en, rd_en, ctrl_wr, disable_wr, tstat_w1c, run;
    logic        tmo_hit, idle_hit, cap_ev, tmo_ev;
    logic        irq_en_bit, irq_pend_bit;
    logic [31:0] tlimit_q, tlimit_d, rdata_mux;
    logic [31:0] cnt_q, idle_cnt_q, hi_latch_q, width_q, period_q;
    logic        enable_q, valid_q, timeout_q;
    state_e      state_q;

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (csi_clk),
        .rst_n_i (rsi_rst_n),
        .pwm_i   (coe_pwm_in),
        .level_o (pwm_level),
        .rise_o  (pwm_rise),
        .fall_o  (pwm_fall)
    );

    assign wr_en      = avs_s0_chip_select & avs_s0_write;
    assign rd_en      = avs_s0_chip_select & avs_s0_read;
    assign ctrl_wr    = wr_en && (avs_s0_address == ADDR_CTRL) && avs_s0_byteenable[0];
    assign disable_wr = ctrl_wr & ~avs_s0_writedata[CTRL_ENABLE];
    assign tstat_w1c  = ctrl_wr & avs_s0_writedata[CTRL_TIMEOUT];
    // A disable write in flight overrides any edge seen in the same cycle.
    assign run        = enable_q & ~disable_wr;
    assign tmo_hit    = (tlimit_q != 32'd0) && (cnt_q >= tlimit_q);
    assign idle_hit   = (tlimit_q != 32'd0) && (idle_cnt_q >= tlimit_q);

    always_comb begin
        cap_ev = run && (state_q == ST_LOW) && !tmo_hit && pwm_rise;
        tmo_ev = run && ((((state_q == ST_HIGH) || (state_q == ST_LOW)) && tmo_hit) ||
                         ((state_q == ST_WAIT_RISE) && !pwm_rise && idle_hit));
    end

    always_comb begin
        tlimit_d = tlimit_q;
        if (wr_en && (avs_s0_address == ADDR_TIMEOUT)) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_s0_byteenable[b]) tlimit_d[8*b +: 8] = avs_s0_writedata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            tlimit_q <= TIMEOUT_DEFAULT;
            enable_q <= 1'b0;
        end else begin
            tlimit_q <= tlimit_d;
            if (ctrl_wr) enable_q <= avs_s0_writedata[CTRL_ENABLE];
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
            hi_latch_q <= '0;
            width_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (!run) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                idle_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q    <= ST_WAIT_RISE;
                        cnt_q      <= '0;
                        idle_cnt_q <= '0;
                    end
                    ST_WAIT_RISE: begin
                        cnt_q <= '0;
                        if (pwm_rise) begin
                            state_q    <= ST_HIGH;
                            cnt_q      <= 32'd1;
                            idle_cnt_q <= '0;
                        end else if (idle_hit) begin
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= sat_inc(idle_cnt_q);
                        end
                    end
                    ST_HIGH: begin
                        if (tmo_hit) begin
                            state_q <= ST_WAIT_RISE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                            if (pwm_fall) begin
                                state_q    <= ST_LOW;
                                hi_latch_q <= cnt_q;
                            end
                        end
                    end
                    ST_LOW: begin
                        if (tmo_hit) begin
                            state_q <= ST_WAIT_RISE;
                            cnt_q   <= '0;
                        end else if (pwm_rise) begin
                            state_q  <= ST_HIGH;
                            cnt_q    <= 32'd1;
                            width_q  <= hi_latch_q;
                            period_q <= cnt_q;
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

            if (!run) begin
                valid_q   <= 1'b0;
                timeout_q <= 1'b0;
            end else if (cap_ev) begin
                valid_q   <= 1'b1;
                timeout_q <= 1'b0;
            end else if (tmo_ev) begin
                valid_q   <= 1'b0;
                timeout_q <= 1'b1;
            end else if (tstat_w1c) begin
                timeout_q <= 1'b0;
            end
        end
    end

`ifdef PWM_CAPTURE_IRQ_EN
    logic irq_en_q, irq_pend_q;

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= avs_s0_writedata[CTRL_IRQ_EN];
            if (cap_ev || tmo_ev)
                irq_pend_q <= 1'b1;
            else if (ctrl_wr && avs_s0_writedata[CTRL_IRQ_PEND])
                irq_pend_q <= 1'b0;
        end
    end

    assign irq_en_bit   = irq_en_q;
    assign irq_pend_bit = irq_pend_q;
    assign ins_irq      = irq_pend_q & irq_en_q;
`else
    assign irq_en_bit   = 1'b0;
    assign irq_pend_bit = 1'b0;
`endif

    always_comb begin
        rdata_mux = '0;
        case (avs_s0_address)
            ADDR_WIDTH:   rdata_mux = width_q;
            ADDR_PERIOD:  rdata_mux = period_q;
            ADDR_CTRL: begin
                rdata_mux[CTRL_ENABLE]   = enable_q;
                rdata_mux[CTRL_VALID]    = valid_q;
                rdata_mux[CTRL_TIMEOUT]  = timeout_q;
                rdata_mux[CTRL_LEVEL]    = pwm_level;
                rdata_mux[CTRL_IRQ_EN]   = irq_en_bit;
                rdata_mux[CTRL_IRQ_PEND] = irq_pend_bit;
            end
            ADDR_TIMEOUT: rdata_mux = tlimit_q;
            default:      rdata_mux = '0;
        endcase
    end

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) avs_s0_readdata <= '0;
        else if (rd_en) avs_s0_readdata <= rdata_mux;
    end

endmodule

`default_nettype wire

// File: doc/pwm_capture_avalon.md
Name: pwm_capture_avalon

Overview:
- Avalon-MM slave PWM receiver: measures pulse width (high time) and period of an external PWM signal, in `csi_clk` cycles.
- Receive-side counterpart of the team's PWM generator.
- Sits on the Qsys interconnect beside the generator. Typical uses: loop-back checking of generated PWM, and reading servo/sensor PWM inputs.

Parameters:
- TIMEOUT_DEFAULT, 1000000, reset value of the timeout-limit register in clock cycles.
- SYNC_STAGES, 2, input synchronizer depth; legal values are 2 or 3.

Ports:
- csi_clk  input  1  system clock; sole clock.
- rsi_rst_n  input  1  reset, asynchronous assert, active-low.
- avs_s0_chip_select  input  1  slave select.
- avs_s0_read  input  1  read strobe.
- avs_s0_write  input  1  write strobe.
- avs_s0_address  input  2  word address.
- avs_s0_byteenable  input  4  write byte lanes.
- avs_s0_writedata  input  32  write data.
- avs_s0_readdata  output  32  read data, registered.
- coe_pwm_in  input  1  asynchronous PWM input (conduit).

Behaviour:
- Clock and reset:
  - One clock only.
  - Reset is asynchronous and active-low; every flop clears on negedge of rsi_rst_n.
- Register map (word address):
  - 0: WIDTH (RO), last captured high time.
  - 1: PERIOD (RO), last captured rise-to-rise time.
  - 2: CTRL/STATUS.
    - bit0 enable (RW, written via byteenable[0]).
    - bit1 valid (RO).
    - bit2 timeout (RO).
    - bit3 current synchronized input level (RO).
    - All other bits read 0.
  - 3: TIMEOUT limit (RW, per-byte-lane writes).
- Reset values:
  - readdata = 0, WIDTH = 0, PERIOD = 0.
  - enable = 0, valid = 0, timeout = 0.
  - TIMEOUT = TIMEOUT_DEFAULT.
  - FSM = IDLE, counter = 0, synchronizer = 0.
- Reads:
  - avs_s0_readdata is registered when chip_select & read: one-cycle read latency, no waitrequest.
  - readdata holds its value when not reading.
- Input conditioning:
  - coe_pwm_in passes through SYNC_STAGES flops, plus one more flop for edge detection.
  - rise = cur & ~prev; fall = ~cur & prev.
- FSM states:
  - IDLE:
    - Entered whenever enable = 0; counter held at 0.
    - enable = 1 -> WAIT_RISE.
  - WAIT_RISE:
    - Counter held at 0.
    - rise -> HIGH, counter <= 1.
  - HIGH:
    - counter += 1 each cycle.
    - fall -> LOW; hi_latch <= counter.
  - LOW:
    - counter += 1 each cycle.
    - rise -> WIDTH <= hi_latch, PERIOD <= counter, valid <= 1, counter <= 1, state HIGH (back-to-back capture).
- Worked timing example: input high N cycles then low M cycles gives WIDTH = N and PERIOD = N+M. Captured values appear in the registers on the cycle after the rise edge is detected.
- Timeout:
  - Applies in WAIT_RISE, HIGH and LOW.
  - In HIGH/LOW: counter >= TIMEOUT (with TIMEOUT != 0) -> timeout <= 1, valid <= 0, state WAIT_RISE.
  - In WAIT_RISE a separate idle count uses the same limit; it covers 0 % and 100 % duty.
  - bit3 distinguishes stuck-low from stuck-high.
  - TIMEOUT = 0 disables timeout.
- Counter saturates at 32'hFFFF_FFFF; it never wraps.
- Clearing status:
  - timeout clears on the next successful capture, or on a write with writedata[2] = 1 (W1C).
  - valid clears only on timeout, disable, or reset.
- Disable:
  - Writing enable = 0 clears valid and timeout and enters IDLE next cycle.
  - WIDTH and PERIOD keep their last values.
- Simultaneous events:
  - A disable write in the same cycle as a rise: disable wins, no capture.
  - A read in the same cycle as a capture returns the pre-capture value.
- Reset mid-measurement discards the partial count.

Optional Feature:
- Macro PWM_CAPTURE_IRQ_EN.
- When defined:
  - Adds output port ins_irq (1 bit) and CTRL bit4 irq_en (RW) and bit5 irq_pend (RO, W1C via writedata[5]).
  - irq_pend sets on every capture or timeout; ins_irq = irq_pend & irq_en.
  - Reset value 0.
- When undefined: no port, and bits 4/5 read 0 and ignore writes.

Decomposition:
- Package pwm_capture_pkg:
  - Address localparams ADDR_WIDTH = 0, ADDR_PERIOD = 1, ADDR_CTRL = 2, ADDR_TIMEOUT = 3.
  - CTRL bit-index constants.
  - FSM state encoding (IDLE, WAIT_RISE, HIGH, LOW; 2 bits).
- One sub-module, pwm_edge_sync:
  - Synchronizer plus edge detector.
  - Outputs level, rise, fall.
- Register file and FSM stay in the top module.

Test Plan:
- Reset, then read addresses 0–3 -> 0, 0, 0, TIMEOUT_DEFAULT. readdata changes exactly one cycle after the read strobe.
- Enable, drive 30 high / 70 low for 3 periods -> after the 2nd rise, WIDTH = 30, PERIOD = 100, valid = 1. Values are unchanged on subsequent periods.
- Change input to 1 high / 1 low (fastest) -> WIDTH = 1, PERIOD = 2. Then 99 high / 1 low -> WIDTH = 99, PERIOD = 100.
- TIMEOUT = 500, hold input high after a rise -> timeout = 1, valid = 0, bit3 = 1 at about 500 cycles. Resume PWM -> timeout clears on the next capture.
- Write TIMEOUT with byteenable = 4'b0001, data 0xFFFF_FF10 -> only bits [7:0] change. Write enable = 0 on the same cycle as a rise edge -> no capture, state IDLE.
- With PWM_CAPTURE_IRQ_EN, irq_en = 1, 50/50 PWM -> ins_irq asserts the cycle after a capture. W1C of bit5 deasserts it until the next capture.
